// File: rtl/bist_sequencer.sv
// BIST session sequencer for the four-function engine.
// For each function f = 0..3 it:
//   - reseeds the pattern LFSR and clears the MISR;
//   - applies PATTERNS patterns, each one an engine start, a busy handshake and a MISR/LFSR step;
//   - compares the final MISR signature against golden slice f.
// Results stay valid in DONE until the next accepted start or reset.
//
// Ports:
//   clock, rst          rising-edge clock, asynchronous active-high reset
//   start               session request, honoured only in IDLE/DONE
//   seed, poly, golden  session configuration, latched on an accepted start
//   misr_sig            current MISR signature
//   cut_busy            engine busy handshake
//   lfsr_load, lfsr_en  LFSR reseed / step strobes
//   misr_clear, misr_en MISR clear / compact strobes
//   cut_start, cut_func engine start strobe and function select
//   seed_q, poly_q      latched configuration fed to LFSR/MISR
//   busy, done          session in progress / finished (level)
//   pass, fail_map      overall pass, per-function mismatch bits
//   timeout, cfg_err    engine handshake timeout, zero seed/poly at start
module bist_sequencer #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PATTERNS = 16,
    parameter int unsigned TIMEOUT  = 32
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   seed,
    input  logic [WIDTH-1:0]   poly,
    input  logic [4*WIDTH-1:0] golden,
    input  logic [WIDTH-1:0]   misr_sig,
    input  logic               cut_busy,
    output logic               lfsr_load,
    output logic               lfsr_en,
    output logic               misr_clear,
    output logic               misr_en,
    output logic               cut_start,
    output logic [1:0]         cut_func,
    output logic [WIDTH-1:0]   seed_q,
    output logic [WIDTH-1:0]   poly_q,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [3:0]         fail_map,
    output logic               timeout,
    output logic               cfg_err
);

    localparam int unsigned PAT_W  = (PATTERNS > 1) ? $clog2(PATTERNS) : 1;
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StApply,
        StWait,
        StCapture,
        StCheck,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         func_q, func_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [WAIT_W-1:0]  wait_q, wait_d, wait_inc;
    logic [WIDTH-1:0]   seed_d, poly_d, gold_sel;
    logic [4*WIDTH-1:0] golden_q, golden_d;
    logic               pass_q, pass_d, timeout_q, timeout_d, cfg_q, cfg_d;
    logic [3:0]         fail_q, fail_d, fail_upd;

    assign cut_func = func_q;
    assign pass     = pass_q;
    assign fail_map = fail_q;
    assign timeout  = timeout_q;
    assign cfg_err  = cfg_q;

    always_comb begin
        gold_sel = golden_q[0 +: WIDTH];
        unique case (func_q)
            2'd0: gold_sel = golden_q[0 +: WIDTH];
            2'd1: gold_sel = golden_q[WIDTH +: WIDTH];
            2'd2: gold_sel = golden_q[2*WIDTH +: WIDTH];
            2'd3: gold_sel = golden_q[3*WIDTH +: WIDTH];
            default: gold_sel = golden_q[0 +: WIDTH];
        endcase
    end

    always_comb begin
        state_d    = state_q;
        func_d     = func_q;
        pat_d      = pat_q;
        wait_d     = wait_q;
        wait_inc   = wait_q + WAIT_W'(1);
        seed_d     = seed_q;
        poly_d     = poly_q;
        golden_d   = golden_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        fail_upd   = fail_q;
        timeout_d  = timeout_q;
        cfg_d      = cfg_q;
        lfsr_load  = 1'b0;
        lfsr_en    = 1'b0;
        misr_clear = 1'b0;
        misr_en    = 1'b0;
        cut_start  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                done = (state_q == StDone);
                if (start) begin
                    seed_d    = seed;
                    poly_d    = poly;
                    golden_d  = golden;
                    pass_d    = 1'b0;
                    fail_d    = 4'b0000;
                    timeout_d = 1'b0;
                    cfg_d     = 1'b0;
                    pat_d     = '0;
                    if (seed == '0 || poly == '0) begin
                        cfg_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        // func select only moves on a LOAD entry edge
                        func_d  = 2'd0;
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                busy       = 1'b1;
                lfsr_load  = 1'b1;
                misr_clear = 1'b1;
                pat_d      = '0;
                state_d    = StApply;
            end
            StApply: begin
                busy      = 1'b1;
                cut_start = 1'b1;
                wait_d    = '0;
                state_d   = StWait;
            end
            StWait: begin
                busy   = 1'b1;
                wait_d = wait_inc;
                // first WAIT cycle is engine start latency; busy is not yet meaningful
                if (wait_q != '0 && !cut_busy) begin
                    state_d = StCapture;
                end else if (wait_inc == WAIT_W'(TIMEOUT)) begin
                    timeout_d      = 1'b1;
                    pass_d         = 1'b0;
                    fail_d[func_q] = 1'b1;
                    state_d        = StDone;
                end
            end
            StCapture: begin
                busy    = 1'b1;
                misr_en = 1'b1;
                lfsr_en = 1'b1;
                if (pat_q == PAT_W'(PATTERNS - 1)) begin
                    state_d = StCheck;
                end else begin
                    pat_d   = pat_q + PAT_W'(1);
                    state_d = StApply;
                end
            end
            StCheck: begin
                busy             = 1'b1;
                fail_upd[func_q] = (misr_sig != gold_sel);
                fail_d           = fail_upd;
                if (func_q == 2'd3) begin
                    pass_d  = (fail_upd == 4'b0000);
                    state_d = StDone;
                end else begin
                    func_d  = func_q + 2'd1;
                    state_d = StLoad;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            func_q    <= 2'd0;
            pat_q     <= '0;
            wait_q    <= '0;
            seed_q    <= '0;
            poly_q    <= '0;
            golden_q  <= '0;
            pass_q    <= 1'b0;
            fail_q    <= 4'b0000;
            timeout_q <= 1'b0;
            cfg_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            func_q    <= func_d;
            pat_q     <= pat_d;
            wait_q    <= wait_d;
            seed_q    <= seed_d;
            poly_q    <= poly_d;
            golden_q  <= golden_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            timeout_q <= timeout_d;
            cfg_q     <= cfg_d;
        end
    end

endmodule

// File: tb/tb_bist_sequencer.sv
// Scoreboard bench for bist_sequencer: a small LFSR/engine/MISR environment drives the
// handshake, stimulus pushes expected session results, a monitor checks them on done.
module tb_bist_sequencer;

    localparam int W   = 8;
    localparam int PAT = 4;
    localparam int TO  = 32;

    logic          clock = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  seed = '0, poly = '0;
    logic [4*W-1:0] golden = '0;
    logic [W-1:0]  misr_sig;
    logic          cut_busy;
    logic          lfsr_load, lfsr_en, misr_clear, misr_en, cut_start;
    logic [1:0]    cut_func;
    logic [W-1:0]  seed_q, poly_q;
    logic          busy, done, pass, timeout, cfg_err;
    logic [3:0]    fail_map;

    bist_sequencer #(.WIDTH(W), .PATTERNS(PAT), .TIMEOUT(TO)) dut (
        .clock(clock), .rst(rst), .start(start), .seed(seed), .poly(poly),
        .golden(golden), .misr_sig(misr_sig), .cut_busy(cut_busy),
        .lfsr_load(lfsr_load), .lfsr_en(lfsr_en), .misr_clear(misr_clear),
        .misr_en(misr_en), .cut_start(cut_start), .cut_func(cut_func),
        .seed_q(seed_q), .poly_q(poly_q), .busy(busy), .done(done), .pass(pass),
        .fail_map(fail_map), .timeout(timeout), .cfg_err(cfg_err)
    );

    always #5 clock = ~clock;

    // ---------------- environment: LFSR, engine, MISR ----------------
    function automatic logic [7:0] lfsr_step(input logic [7:0] l, input logic [7:0] p);
        return (l >> 1) ^ (l[0] ? p : 8'h00);
    endfunction

    function automatic logic [7:0] misr_step(input logic [7:0] m, input logic [7:0] r,
                                             input logic [7:0] p);
        return ({m[6:0], 1'b0} ^ (m[7] ? p : 8'h00)) ^ r;
    endfunction

    function automatic logic [7:0] eng_fn(input logic [1:0] f, input logic [7:0] x);
        case (f)
            2'd0: return x;
            2'd1: return ~x;
            2'd2: return {x[3:0], x[7:4]};
            default: return x ^ 8'h3C;
        endcase
    endfunction

    function automatic logic [31:0] calc_golden(input logic [7:0] s, input logic [7:0] p);
        logic [31:0] g;
        logic [7:0]  l, m;
        g = '0;
        for (int f = 0; f < 4; f++) begin
            l = s;
            m = 8'h00;
            for (int k = 0; k < PAT; k++) begin
                m = misr_step(m, eng_fn(2'(f), l), p);
                l = lfsr_step(l, p);
            end
            g[8*f +: 8] = m;
        end
        return g;
    endfunction

    logic [7:0] lfsr, misr, eng_res;
    logic       eng_q, hang, hang_en = 1'b0;
    int         pat_idx;

    always @(posedge clock or posedge rst) begin
        if (rst) begin
            lfsr <= '0; misr <= '0; eng_res <= '0; eng_q <= 1'b0; hang <= 1'b0; pat_idx <= 0;
        end else begin
            if (lfsr_load) lfsr <= seed_q;
            else if (lfsr_en) lfsr <= lfsr_step(lfsr, poly_q);
            if (misr_clear) misr <= 8'h00;
            else if (misr_en) misr <= misr_step(misr, eng_res, poly_q);
            eng_q <= cut_start;
            if (cut_start) eng_res <= eng_fn(cut_func, lfsr);
            if (lfsr_load) begin
                pat_idx <= 0;
                hang    <= 1'b0;
            end else if (cut_start) begin
                pat_idx <= pat_idx + 1;
                if (hang_en && cut_func == 2'd1 && pat_idx == 0) hang <= 1'b1;
            end
        end
    end

    // Engine is busy on the start cycle and the one after (clears on the 2nd WAIT cycle).
    assign cut_busy = cut_start | eng_q | hang;
    assign misr_sig = misr;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic       pass;
        logic [3:0] fmap;
        logic       to;
        logic       cfg;
        int         busy_cyc;
        int         starts;
        int         loads;
        logic [7:0] seed;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_exp(input logic ps, input logic [3:0] fm, input logic to,
                            input logic cfg, input int bc, input int st, input int ld,
                            input logic [7:0] sd);
        exp_t e;
        e.pass = ps; e.fmap = fm; e.to = to; e.cfg = cfg;
        e.busy_cyc = bc; e.starts = st; e.loads = ld; e.seed = sd;
        exp_q.push_back(e);
    endtask

    int   mon_busy = 0, mon_starts = 0, mon_loads = 0, excl_err = 0;
    logic done_prev = 1'b0;

    always @(negedge clock) begin
        logic [4:0] s;
        exp_t e;
        if (rst) begin
            mon_busy = 0; mon_starts = 0; mon_loads = 0; done_prev = 1'b0;
        end else begin
            if (busy) mon_busy++;
            if (cut_start) mon_starts++;
            if (lfsr_load) mon_loads++;
            s = {lfsr_load, misr_clear, cut_start, misr_en, lfsr_en};
            if (!(s inside {5'b00000, 5'b11000, 5'b00100, 5'b00011}) || (s != 0 && !busy))
                excl_err++;
            if (done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pass", 32'(pass), 32'(e.pass));
                    chk("fail_map", 32'(fail_map), 32'(e.fmap));
                    chk("timeout", 32'(timeout), 32'(e.to));
                    chk("cfg_err", 32'(cfg_err), 32'(e.cfg));
                    chk("busy_cycles", 32'(mon_busy), 32'(e.busy_cyc));
                    chk("cut_start_count", 32'(mon_starts), 32'(e.starts));
                    chk("lfsr_load_count", 32'(mon_loads), 32'(e.loads));
                    chk("seed_q", 32'(seed_q), 32'(e.seed));
                end
                mon_busy = 0; mon_starts = 0; mon_loads = 0;
            end
            done_prev = done;
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_start(input logic [7:0] s, input logic [7:0] p, input logic [31:0] g);
        @(negedge clock);
        seed = s; poly = p; golden = g; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clock);
            n++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clock);
    endtask

    task automatic pulse_reset();
        @(negedge clock); rst = 1'b1;
        @(negedge clock); rst = 1'b0;
    endtask

    function automatic logic [31:0] all_outs();
        return {lfsr_load, lfsr_en, misr_clear, misr_en, cut_start, cut_func, seed_q, poly_q,
                busy, done, pass, fail_map, timeout, cfg_err};
    endfunction

    logic [31:0] g_a, g_c;
    logic        found;

    initial begin
        g_a = calc_golden(8'h5A, 8'hB8);
        g_c = calc_golden(8'hC3, 8'hB8);

        // Reset state
        repeat (3) @(posedge clock);
        #1 chk("reset_outputs", all_outs(), 32'd0);
        @(negedge clock); rst = 1'b0;

        // Golden match: 4 x (1 + 4*4 + 1) = 72 busy cycles
        push_exp(1'b1, 4'b0000, 1'b0, 1'b0, 72, 16, 4, 8'h5A);
        do_start(8'h5A, 8'hB8, g_a);
        drain(300);

        // Single mismatch on func 2, started from DONE
        push_exp(1'b0, 4'b0100, 1'b0, 1'b0, 72, 16, 4, 8'h5A);
        do_start(8'h5A, 8'hB8, g_a ^ 32'h0001_0000);
        drain(300);

        // Timeout on func 1 pattern 0: 18 + 1 + 1 + 32 = 52 busy cycles
        hang_en = 1'b1;
        push_exp(1'b0, 4'b0010, 1'b1, 1'b0, 52, 5, 2, 8'h5A);
        do_start(8'h5A, 8'hB8, g_a);
        drain(300);
        repeat (10) @(negedge clock);
        chk("no_start_after_timeout", 32'(mon_starts), 32'd0);
        chk("done_held", 32'(done), 32'd1);
        hang_en = 1'b0;

        // Config errors: straight to DONE, no strobes
        pulse_reset();
        push_exp(1'b0, 4'b0000, 1'b0, 1'b1, 0, 0, 0, 8'h00);
        do_start(8'h00, 8'hB8, g_a);
        drain(20);
        pulse_reset();
        push_exp(1'b0, 4'b0000, 1'b0, 1'b1, 0, 0, 0, 8'h5A);
        do_start(8'h5A, 8'h00, g_a);
        drain(20);

        // Reset mid-session during func 2 WAIT: aborted session has no expectation
        do_start(8'h5A, 8'hB8, g_a);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clock);
            if (cut_start && cut_func == 2'd2) found = 1'b1;
        end
        chk("reached_func2_apply", 32'(found), 32'd1);
        @(posedge clock);
        #2 rst = 1'b1;
        #1 chk("async_reset_outputs", all_outs(), 32'd0);
        repeat (2) @(negedge clock);
        rst = 1'b0;
        repeat (3) @(negedge clock);
        chk("idle_after_reset", 32'({busy, done}), 32'd0);
        push_exp(1'b1, 4'b0000, 1'b0, 1'b0, 72, 16, 4, 8'h5A);
        do_start(8'h5A, 8'hB8, g_a);
        drain(300);

        // Start while busy is ignored
        push_exp(1'b1, 4'b0000, 1'b0, 1'b0, 72, 16, 4, 8'h5A);
        do_start(8'h5A, 8'hB8, g_a);
        repeat (10) @(negedge clock);
        seed = 8'h33; poly = 8'h1D; golden = 32'h0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("seed_hold_while_busy", 32'(seed_q), 32'h5A);
        drain(300);

        // Restart from DONE with a new seed: done clears on the accepting edge
        push_exp(1'b1, 4'b0000, 1'b0, 1'b0, 72, 16, 4, 8'hC3);
        @(negedge clock);
        seed = 8'hC3; poly = 8'hB8; golden = g_c; start = 1'b1;
        @(posedge clock);
        #1;
        chk("done_clears_on_restart", 32'(done), 32'd0);
        chk("seed_relatched", 32'(seed_q), 32'hC3);
        @(negedge clock);
        start = 1'b0;
        drain(300);

        chk("strobe_exclusivity", 32'(excl_err), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bist_sequencer.md
Name: bist_sequencer

Overview:
- Sequences one full BIST session over the four-function engine.
- Seeds and steps the pattern LFSR, starts the engine once per pattern, waits on its busy handshake and clocks the MISR on each result.
- After each function's pattern run, compares the MISR signature with a golden value; reports per-function pass/fail, timeout and configuration errors.

Parameters:
- WIDTH, 8, data/seed/poly/signature width.
- PATTERNS, 16, patterns applied per function (>=1).
- TIMEOUT, 32, maximum WAIT cycles per pattern before abort.

Ports:
- clock  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  session request; sampled only in IDLE or DONE.
- seed  in  WIDTH  LFSR seed; latched on accepted start.
- poly  in  WIDTH  LFSR/MISR polynomial; latched on accepted start.
- golden  in  4*WIDTH  expected signatures; [WIDTH*f +: WIDTH] belongs to func f; latched on accepted start.
- misr_sig  in  WIDTH  current MISR signature.
- cut_busy  in  1  engine busy.
- lfsr_load  out  1  load seed_q/poly_q into LFSR.
- lfsr_en  out  1  advance LFSR one step.
- misr_clear  out  1  clear MISR to 0.
- misr_en  out  1  compact current engine result.
- cut_start  out  1  one-cycle engine start.
- cut_func  out  2  function select, equals func_idx.
- seed_q, poly_q  out  WIDTH  latched config driven to LFSR/MISR.
- busy  out  1  session in progress.
- done  out  1  session finished; level.
- pass  out  1  all four signatures matched; valid when done=1.
- fail_map  out  4  bit f set = func f mismatch.
- timeout  out  1  engine handshake timed out.
- cfg_err  out  1  seed==0 or poly==0 at start.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0. Reset mid-session aborts immediately; no partial result is kept.
- States: IDLE, LOAD, APPLY, WAIT, CAPTURE, CHECK, DONE.
- IDLE/DONE, start=1:
  - Latch seed, poly, golden; clear done/pass/fail_map/timeout/cfg_err.
  - func_idx=0, pat_cnt=0.
  - If seed==0 or poly==0: cfg_err=1, go to DONE (pass=0). Otherwise go to LOAD.
- LOAD (1 cycle): lfsr_load=1, misr_clear=1, pat_cnt=0 → APPLY.
- APPLY (1 cycle): cut_start=1 → WAIT; wait counter cleared.
- WAIT:
  - Counter increments every cycle.
  - cut_busy is ignored on the first WAIT cycle; it counts as engine start latency.
  - From the second WAIT cycle, cut_busy==0 → CAPTURE.
  - Counter reaching TIMEOUT while still waiting → DONE with timeout=1, pass=0. fail_map bit for the current func is set; earlier bits keep their values.
- CAPTURE (1 cycle): misr_en=1, lfsr_en=1.
  - If pat_cnt==PATTERNS-1 → CHECK.
  - Otherwise pat_cnt+1 → APPLY.
- CHECK (1 cycle): fail_map[func_idx] = (misr_sig != golden slice).
  - If func_idx==3 → DONE; pass = (updated fail_map==0).
  - Otherwise func_idx+1 → LOAD. Each function reseeds the LFSR and restarts the MISR from 0.
- DONE: done=1 held until the next accepted start or reset. A start here begins a new session from the same cycle, as in IDLE.
- Strobe exclusivity: lfsr_load, misr_clear, cut_start, misr_en and lfsr_en are single-cycle strobes, asserted only in the states above. Never two of them from different states in the same cycle.
- busy=1 in LOAD, APPLY, WAIT, CAPTURE and CHECK; busy=0 in IDLE and DONE.
- start is ignored while busy=1.
- cut_func changes only on the LOAD entry edge; it is stable for the whole function run.
- Nominal pattern period (engine busy clear on 2nd WAIT cycle): 4 cycles.
- Nominal session length: 4 × (1 LOAD + 4·PATTERNS + 1 CHECK) cycles, then DONE.
- Counter widths: pat_cnt wide enough for PATTERNS-1; wait counter wide enough for TIMEOUT; no wrap-around permitted.

Test Plan:
- Golden match: PATTERNS=4, seed=8'h5A, poly=8'hB8, engine model busy for 2 cycles, golden = model-computed signatures → done=1, pass=1, fail_map=0, session takes 4×(1+4·4+1)=72 cycles after start.
- Single mismatch: same setup, golden slice for func 2 XOR 8'h01 → pass=0, fail_map=4'b0100, other bits 0.
- Timeout: engine holds cut_busy=1 during func 1, pattern 0 → after 32 WAIT cycles timeout=1, done=1, pass=0, fail_map=4'b0010, no further cut_start.
- Config error: start with seed=0 → cfg_err=1, done=1 one cycle later, no lfsr_load/cut_start pulses; repeat with poly=0 → same.
- Reset mid-session: assert rst during func 2 WAIT → all outputs 0 asynchronously, state IDLE. New start after release runs a full clean session with pass=1.
- Start handling: pulse start while busy → ignored, latched seed unchanged. Pulse start in DONE with a new seed → session restarts, done clears on the next edge.
